// File: rtl/memory_pkg.sv
// Shared memory-side types for the data-bus arbiter.
//   dbus_req_t       : request channel (valid, addr, size, strobe, data)
//   dbus_resp_t      : response channel (data_ok, data)
//   dbus_arb_state_t : arbiter FSM state {IDLE, LOCKED}
//   DBUS_ARB_MAX_CH  : largest supported channel count
//   ch_idx_t         : channel index wide enough for DBUS_ARB_MAX_CH
package memory_pkg;

    localparam int DBUS_ARB_MAX_CH = 8;

    typedef logic [$clog2(DBUS_ARB_MAX_CH)-1:0] ch_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } dbus_arb_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_arb_pick.sv
// Combinational winner selection for dbus_arbiter.
//   valid       : per-channel valid
//   write       : per-channel "valid and strobe nonzero"
//   start       : first channel searched; the search wraps modulo N_CH
//   write_first : writes form a higher class searched before reads
//   winner      : selected channel (meaningful when any_valid)
//   any_valid   : at least one channel is valid
// Fixed priority is the special case start = 0.
module dbus_arb_pick #(
    parameter int N_CH  = 2,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [N_CH-1:0]  write,
    input  logic [IDX_W-1:0] start,
    input  logic             write_first,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    // First set bit of vec at or after st, wrapping around to index 0.
    function automatic logic [IDX_W-1:0] first_from(input logic [N_CH-1:0] vec,
                                                    input logic [IDX_W-1:0] st);
        logic [IDX_W-1:0] r;
        logic             hit;
        r   = '0;
        hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!hit && vec[i] && (i >= int'(st))) begin
                r   = IDX_W'(i);
                hit = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!hit && vec[i]) begin
                r   = IDX_W'(i);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        any_valid = |valid;
        if (write_first && (|write)) begin
            winner = first_from(write, start);
        end else begin
            winner = first_from(valid, start);
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// N-channel arbiter in front of the core data bus.
//   clk, reset : clock, synchronous active-high reset
//   ch_req     : per-channel requests          ch_resp  : per-channel responses
//   dreq       : request to the data bus       dresp    : response from the bus
//   grant_id   : channel driving dreq          busy     : lock held (LOCKED)
//   proto_err  : sticky, locked channel dropped valid before data_ok
//   done_cnt   : completed transactions per channel (wrapping)
//   dbg_state  : current FSM state
// Handshake: a requester raises valid with a stable payload and keeps both
// until it sees its own ch_resp.data_ok; a transaction completes in any cycle
// where dreq.valid and dresp.data_ok are both high.
// Build option: define DBUS_ARB_RR_EN for round-robin selection (the pointer
// moves to winner+1 on each completion); otherwise fixed priority from ch 0.
module dbus_arbiter
    import memory_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter bit WRITE_FIRST = 1'b1,
    parameter int CNT_W       = 32,
    localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  dbus_req_t        ch_req   [N_CH],
    output dbus_resp_t       ch_resp  [N_CH],
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy,
    output logic             proto_err,
    output logic [CNT_W-1:0] done_cnt [N_CH],
    output dbus_arb_state_t  dbg_state
);

    dbus_arb_state_t  state, state_next;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] start;
    logic [N_CH-1:0]  valid_vec;
    logic [N_CH-1:0]  write_vec;
    logic             any_valid;
    logic             lock_valid;
    logic             req_valid;
    logic             fire;
    logic             drop;

    always_comb begin
        valid_vec = '0;
        write_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            valid_vec[i] = ch_req[i].valid;
            write_vec[i] = ch_req[i].valid && (ch_req[i].strobe != '0);
        end
    end

`ifdef DBUS_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= (sel == IDX_W'(N_CH - 1)) ? '0 : sel + IDX_W'(1);
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    dbus_arb_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid       (valid_vec),
        .write       (write_vec),
        .start       (start),
        .write_first (WRITE_FIRST),
        .winner      (win_idx),
        .any_valid   (any_valid)
    );

    // Selected channel and whether it may drive the bus this cycle. Reset
    // suppresses the bus so no completion is routed in the reset cycle.
    always_comb begin
        lock_valid = ch_req[grant_q].valid;
        sel        = grant_q;
        req_valid  = 1'b0;
        if (state == IDLE) begin
            sel       = win_idx;
            req_valid = any_valid;
        end else begin
            req_valid = lock_valid;
        end
        if (reset) begin
            req_valid = 1'b0;
        end
    end

    assign fire = req_valid && dresp.data_ok;
    assign drop = (state == LOCKED) && !lock_valid && !reset;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && any_valid) begin
                grant_q <= sel;
            end
            if (drop) begin
                proto_err <= 1'b1;
            end
        end
    end

    // FSM: next state. Completion always returns to IDLE, so a new grant
    // is only made the cycle after data_ok.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid && !dresp.data_ok) state_next = LOCKED;
            LOCKED:  if (!lock_valid || dresp.data_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs. Copying the granted payload verbatim means a read
    // (strobe 0) can never reach the bus with a nonzero strobe.
    always_comb begin
        dreq = '0;
        if (req_valid) begin
            dreq = ch_req[sel];
        end
        grant_id  = ((state == IDLE) && any_valid) ? win_idx : grant_q;
        busy      = (state == LOCKED);
        dbg_state = state;
        for (int i = 0; i < N_CH; i++) begin
            ch_resp[i].data_ok = fire && (sel == IDX_W'(i));
            ch_resp[i].data    = dresp.data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (reset) begin
                done_cnt[i] <= '0;
            end else if (fire && (sel == IDX_W'(i))) begin
                done_cnt[i] <= done_cnt[i] + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;
    import memory_pkg::*;

    // Instance A: two channels, writes first. Instance B: four channels,
    // plain priority, used for the rotation sequence and random traffic.
    localparam bit B_WF = 1'b0;
`ifdef DBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [63:0] RESP_DATA = 64'hDA7A_0000_0000_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dbus_req_t       a_req  [2];
    dbus_resp_t      a_resp [2];
    dbus_req_t       a_dreq;
    dbus_resp_t      a_dresp;
    logic [0:0]      a_grant;
    logic            a_busy, a_perr;
    logic [31:0]     a_cnt  [2];
    dbus_arb_state_t a_state;

    dbus_req_t       b_req  [4];
    dbus_resp_t      b_resp [4];
    dbus_req_t       b_dreq;
    dbus_resp_t      b_dresp;
    logic [1:0]      b_grant;
    logic            b_busy, b_perr;
    logic [31:0]     b_cnt  [4];
    dbus_arb_state_t b_state;

    dbus_arbiter #(.N_CH(2), .WRITE_FIRST(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .ch_req(a_req), .ch_resp(a_resp),
        .dreq(a_dreq), .dresp(a_dresp), .grant_id(a_grant), .busy(a_busy),
        .proto_err(a_perr), .done_cnt(a_cnt), .dbg_state(a_state)
    );

    dbus_arbiter #(.N_CH(4), .WRITE_FIRST(B_WF), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .ch_req(b_req), .ch_resp(b_resp),
        .dreq(b_dreq), .dresp(b_dresp), .grant_id(b_grant), .busy(b_busy),
        .proto_err(b_perr), .done_cnt(b_cnt), .dbg_state(b_state)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic a_drive(input bit v0, input logic [7:0] s0, input bit v1,
                           input logic [7:0] s1, input bit dok);
        a_req[0]        = '0;
        a_req[0].valid  = v0;
        a_req[0].addr   = 32'h8000_0100;
        a_req[0].size   = 3'd3;
        a_req[0].strobe = s0;
        a_req[0].data   = 64'h0000_0000_0000_AAAA;
        a_req[1]        = '0;
        a_req[1].valid  = v1;
        a_req[1].addr   = 32'h8000_0200;
        a_req[1].size   = 3'd3;
        a_req[1].strobe = s1;
        a_req[1].data   = 64'h0000_0000_0000_BBBB;
        a_dresp.data_ok = dok;
        a_dresp.data    = RESP_DATA;
    endtask

    task automatic b_idle();
        for (int i = 0; i < 4; i++) b_req[i] = '0;
        b_dresp = '0;
    endtask

    // Reset is applied on one edge; returns 1 time unit after that edge.
    task automatic do_reset();
        reset = 1'b1;
        a_drive(0, 8'h00, 0, 8'h00, 0);
        b_idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Inputs change 1 after the edge; checks run 3 after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Search order: start, start+1, ... wrapping; writes as a first class
    // when wf is set, otherwise any pending channel.
    function automatic int model_pick(input bit [3:0] pv, input bit [3:0] pw,
                                      input int st, input bit wf);
        int order[$];
        int res;
        res = -1;
        for (int k = 0; k < 4; k++) order.push_back((st + k) % 4);
        if (wf) begin
            foreach (order[j]) if (res < 0 && pw[order[j]]) res = order[j];
        end
        foreach (order[j]) if (res < 0 && pv[order[j]]) res = order[j];
        return res;
    endfunction

    typedef struct {
        bit         v0;
        logic [7:0] s0;
        bit         v1;
        logic [7:0] s1;
        bit         dok;
        bit         e_valid;
        bit         e_grant;
        logic [1:0] e_ok;
        logic [7:0] e_strb;
    } vec_t;

    vec_t tbl [7];

    bit   [3:0]  m_pend;
    logic [31:0] m_addr [4];
    logic [7:0]  m_strb [4];
    int          m_cnt  [4];
    int          m_owner;
    int          m_ptr;

    initial begin
        reset = 1'b1;
        a_drive(0, 8'h00, 0, 8'h00, 0);
        b_idle();

        //            v0 s0     v1 s1     dok  valid grant ok     strobe
        tbl[0] = '{1, 8'h00, 1, 8'h00, 1,   1,    0,    2'b01, 8'h00};
        tbl[1] = '{1, 8'h00, 1, 8'hFF, 1,   1,    1,    2'b10, 8'hFF};
        tbl[2] = '{1, 8'h0F, 1, 8'hFF, 1,   1,    0,    2'b01, 8'h0F};
        tbl[3] = '{0, 8'h00, 1, 8'h00, 0,   1,    1,    2'b00, 8'h00};
        tbl[4] = '{0, 8'h00, 0, 8'h00, 1,   0,    0,    2'b00, 8'h00};
        tbl[5] = '{1, 8'h03, 1, 8'h00, 1,   1,    0,    2'b01, 8'h03};
        tbl[6] = '{0, 8'h00, 1, 8'hF0, 1,   1,    1,    2'b10, 8'hF0};

        // ---- reset values ----
        do_reset();
        #2;
        check("rst_dreq_zero", a_dreq == '0, 1);
        check("rst_busy", a_busy, 0);
        check("rst_perr", a_perr, 0);
        check("rst_grant", a_grant, 0);
        check("rst_ok", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b00);
        check("rst_cnt0", a_cnt[0], 0);
        check("rst_cnt1", a_cnt[1], 0);
        check("rst_state", a_state, IDLE);

        // ---- table: single-cycle arbitration from IDLE ----
        for (int i = 0; i < 7; i++) begin
            do_reset();
            a_drive(tbl[i].v0, tbl[i].s0, tbl[i].v1, tbl[i].s1, tbl[i].dok);
            #2;
            check($sformatf("tbl%0d_valid", i), a_dreq.valid, tbl[i].e_valid);
            check($sformatf("tbl%0d_ok", i), {a_resp[1].data_ok, a_resp[0].data_ok}, tbl[i].e_ok);
            check($sformatf("tbl%0d_strobe", i), a_dreq.strobe, tbl[i].e_strb);
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_grant", i), a_grant, tbl[i].e_grant);
                check($sformatf("tbl%0d_addr", i), a_dreq.addr,
                      tbl[i].e_grant ? 32'h8000_0200 : 32'h8000_0100);
            end
        end

        // ---- write beats read, locked for 3 cycles, then ch0 ----
        do_reset();
        for (int c = 0; c < 3; c++) begin
            a_drive(1, 8'h00, 1, 8'hFF, c == 2);
            #2;
            check("wf_grant", a_grant, 1);
            check("wf_addr", a_dreq.addr, 32'h8000_0200);
            check("wf_ok", {a_resp[1].data_ok, a_resp[0].data_ok}, (c == 2) ? 2'b10 : 2'b00);
            check("wf_busy", a_busy, c != 0);
            next_cycle();
        end
        a_drive(1, 8'h00, 0, 8'h00, 0);
        #2;
        check("wf_next_grant", a_grant, 0);
        check("wf_next_addr", a_dreq.addr, 32'h8000_0100);
        check("wf_next_busy", a_busy, 0);
        check("wf_cnt1", a_cnt[1], 1);
        check("wf_resp_data", a_resp[0].data, RESP_DATA);
        next_cycle();
        a_drive(1, 8'h00, 0, 8'h00, 1);
        #2;
        check("wf_ch0_ok", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b01);
        next_cycle();
        a_drive(0, 8'h00, 0, 8'h00, 0);
        #2;
        check("wf_cnt0", a_cnt[0], 1);

        // ---- zero-wait completion ----
        do_reset();
        a_drive(1, 8'h00, 0, 8'h00, 1);
        #2;
        check("zw_ok", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b01);
        check("zw_busy", a_busy, 0);
        next_cycle();
        a_drive(0, 8'h00, 0, 8'h00, 0);
        #2;
        check("zw_busy_after", a_busy, 0);
        check("zw_cnt0", a_cnt[0], 1);

        // ---- lock hold against a later write ----
        do_reset();
        a_drive(0, 8'h00, 1, 8'h00, 0);
        #2;
        check("lk_grant0", a_grant, 1);
        next_cycle();
        a_drive(1, 8'hFF, 1, 8'h00, 0);
        #2;
        check("lk_grant1", a_grant, 1);
        check("lk_addr1", a_dreq.addr, 32'h8000_0200);
        check("lk_strobe1", a_dreq.strobe, 8'h00);
        check("lk_ok1", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b00);
        next_cycle();
        a_drive(1, 8'hFF, 1, 8'h00, 1);
        #2;
        check("lk_grant2", a_grant, 1);
        check("lk_ok2", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b10);
        next_cycle();
        a_drive(1, 8'hFF, 0, 8'h00, 0);
        #2;
        check("lk_then_ch0", a_grant, 0);
        check("lk_then_strobe", a_dreq.strobe, 8'hFF);

        // ---- protocol error ----
        do_reset();
        a_drive(1, 8'h00, 0, 8'h00, 0);
        next_cycle();
        a_drive(0, 8'h00, 0, 8'h00, 0);
        #2;
        check("pe_dvalid", a_dreq.valid, 0);
        check("pe_busy_same", a_busy, 1);
        check("pe_perr_same", a_perr, 0);
        next_cycle();
        #2;
        check("pe_state_idle", a_state, IDLE);
        check("pe_perr_set", a_perr, 1);
        next_cycle();
        a_drive(0, 8'h00, 1, 8'h00, 1);
        #2;
        check("pe_perr_sticky", a_perr, 1);
        check("pe_recover_ok", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b10);

        // ---- reset while LOCKED with data_ok pending ----
        do_reset();
        a_drive(0, 8'h00, 1, 8'h00, 0);
        next_cycle();
        reset = 1'b1;
        a_drive(0, 8'h00, 1, 8'h00, 1);
        #2;
        check("rl_no_ok", {a_resp[1].data_ok, a_resp[0].data_ok}, 2'b00);
        next_cycle();
        reset = 1'b0;
        a_drive(0, 8'h00, 0, 8'h00, 0);
        #2;
        check("rl_busy", a_busy, 0);
        check("rl_grant", a_grant, 0);
        check("rl_dreq_zero", a_dreq == '0, 1);
        check("rl_perr", a_perr, 0);
        check("rl_cnt1", a_cnt[1], 0);

        // ---- four reads held, bus answers one cycle after the grant ----
        do_reset();
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                b_req[i]       = '0;
                b_req[i].valid = 1'b1;
                b_req[i].addr  = 32'h9000_0000 + 32'(i * 16);
            end
            b_dresp.data_ok = (c % 2 == 1);
            #2;
            if (c % 2 == 0) check("rr_grant", b_grant, RR ? (c / 2) % 4 : 0);
            next_cycle();
        end
        b_idle();
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_cnt%0d", i), b_cnt[i], RR ? 2 : ((i == 0) ? 8 : 0));
        end

        // ---- random traffic against the model ----
        do_reset();
        m_pend  = '0;
        m_owner = -1;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_addr[i] = '0;
            m_strb[i] = '0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            bit [3:0] pw;
            bit       dok;
            int       ch;
            int       got;
            for (int i = 0; i < 4; i++) begin
                b_req[i]        = '0;
                b_req[i].valid  = m_pend[i];
                b_req[i].addr   = m_addr[i];
                b_req[i].strobe = m_strb[i];
                b_req[i].data   = {32'h0, m_addr[i]};
                pw[i]           = m_pend[i] && (m_strb[i] != 8'h00);
            end
            dok             = ($urandom_range(0, 2) == 0);
            b_dresp.data_ok = dok;
            b_dresp.data    = {$urandom, $urandom};
            ch = (m_owner >= 0) ? m_owner : model_pick(m_pend, pw, m_ptr, B_WF);
            #2;
            check("rnd_valid", b_dreq.valid, ch >= 0);
            if (ch >= 0) begin
                check("rnd_grant", b_grant, ch);
                check("rnd_addr", b_dreq.addr, m_addr[ch]);
                check("rnd_strobe", b_dreq.strobe, m_strb[ch]);
            end
            if (ch >= 0 && dok) exp_q.push_back(ch);
            for (int i = 0; i < 4; i++) begin
                if (b_resp[i].data_ok) begin
                    got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check("rnd_route", i, got);
                end
            end
            check("rnd_sb_drained", exp_q.size(), 0);
            exp_q.delete();
            if (ch >= 0 && dok) begin
                m_cnt[ch]++;
                m_pend[ch] = 1'b0;
                m_owner    = -1;
                m_ptr      = RR ? (ch + 1) % 4 : 0;
            end else if (ch >= 0) begin
                m_owner = ch;
            end
            for (int i = 0; i < 4; i++) begin
                if (!m_pend[i] && $urandom_range(0, 3) == 0) begin
                    m_pend[i] = 1'b1;
                    m_addr[i] = $urandom;
                    m_strb[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                end
            end
            next_cycle();
        end
        b_idle();
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rnd_cnt%0d", i), b_cnt[i], m_cnt[i]);
        end
        check("rnd_perr", b_perr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
